// File: rtl/radio_spi_master_if.sv
// Command handshake and SPI pin bundle between the radio controller and its SPI initiator.
// The slave modport is the initiator's view; master is the command source / pin observer.
interface radio_spi_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_target;
   logic [0:17] cmd_data;
   logic        busy;
   logic        done;
   logic        controller_spi_clk;
   logic        controller_spi_data;
   logic        controller_radio_cs;
   logic        controller_dac_cs;

   modport master (
      output cmd_valid,
      output cmd_target,
      output cmd_data,
      input  cmd_ready,
      input  busy,
      input  done,
      input  controller_spi_clk,
      input  controller_spi_data,
      input  controller_radio_cs,
      input  controller_dac_cs
   );

   modport slave (
      input  cmd_valid,
      input  cmd_target,
      input  cmd_data,
      output cmd_ready,
      output busy,
      output done,
      output controller_spi_clk,
      output controller_spi_data,
      output controller_radio_cs,
      output controller_dac_cs
   );
endinterface

// File: rtl/radio_spi_master.sv
// SPI initiator that serialises one register write to the radio (18 bits) or DAC (16 bits).
// Every output pin comes straight from a flop loaded with the value for the next state.
module radio_spi_master #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned RADIO_BITS = 18,
   parameter int unsigned DAC_BITS   = 16
) (
   input logic               converter_clock_in,
   input logic               reset_n,
   radio_spi_master_if.slave bus
);

   localparam logic [8:0] PhaseLoad = 9'(CLK_DIV - 1);
   // The done cycle is the last gap cycle, so the GAP state itself runs one short.
   localparam logic [8:0] GapLoad   = 9'(2 * CLK_DIV - 2);
   localparam logic [4:0] RadioLast = 5'(RADIO_BITS - 1);
   localparam logic [4:0] DacLast   = 5'(DAC_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLow,
      StHigh,
      StHold,
      StGap
   } state_e;

   state_e      state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [4:0]  bit_q, bit_d;
   logic [17:0] shift_q, shift_d;
   logic        target_q, target_d;

   logic        sclk_q, sclk_d;
   logic        data_q, data_d;
   logic        radio_cs_q, radio_cs_d;
   logic        dac_cs_q, dac_cs_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ready_q, ready_d;

   logic        accept;
   logic        shifting;
   logic [4:0]  last_bit;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      target_d = target_q;
      done_d   = 1'b0;
      accept   = bus.cmd_valid && ready_q;
      last_bit = target_q ? DacLast : RadioLast;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d  = StLow;
               cnt_d    = PhaseLoad;
               bit_d    = '0;
               target_d = bus.cmd_target;
               // DAC words are left-justified so both targets shift out of bit 17.
               shift_d  = bus.cmd_target ? {bus.cmd_data[2:17], 2'b00} : bus.cmd_data;
            end
         end
         StLow: begin
            if (cnt_q == '0) begin
               state_d = StHigh;
               cnt_d   = PhaseLoad;
            end else begin
               cnt_d = cnt_q - 9'd1;
            end
         end
         StHigh: begin
            if (cnt_q == '0) begin
               cnt_d = PhaseLoad;
               if (bit_q == last_bit) begin
                  state_d = StHold;
               end else begin
                  state_d = StLow;
                  bit_d   = bit_q + 5'd1;
                  shift_d = {shift_q[16:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q - 9'd1;
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               state_d = StGap;
               cnt_d   = GapLoad;
            end else begin
               cnt_d = cnt_q - 9'd1;
            end
         end
         StGap: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 9'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      shifting   = (state_d == StLow) || (state_d == StHigh) || (state_d == StHold);
      sclk_d     = (state_d == StHigh);
      data_d     = shifting && shift_d[17];
      radio_cs_d = !(shifting && !target_d);
      dac_cs_d   = !(shifting && target_d);
      busy_d     = (state_d != StIdle);
      ready_d    = (state_d == StIdle);
   end

   always_ff @(posedge converter_clock_in) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         target_q   <= 1'b0;
         sclk_q     <= 1'b0;
         data_q     <= 1'b0;
         radio_cs_q <= 1'b1;
         dac_cs_q   <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         target_q   <= target_d;
         sclk_q     <= sclk_d;
         data_q     <= data_d;
         radio_cs_q <= radio_cs_d;
         dac_cs_q   <= dac_cs_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.cmd_ready           = ready_q;
   assign bus.busy                = busy_q;
   assign bus.done                = done_q;
   assign bus.controller_spi_clk  = sclk_q;
   assign bus.controller_spi_data = data_q;
   assign bus.controller_radio_cs = radio_cs_q;
   assign bus.controller_dac_cs   = dac_cs_q;

endmodule

// File: tb/tb_radio_spi_master.sv
// Bench for radio_spi_master: scoreboard of expected words against a pin-level SPI monitor,
// plus a CLK_DIV=1 instance for the fastest-clock case.
module tb_radio_spi_master;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   initial forever #5 clk = ~clk;

   radio_spi_master_if bus ();
   radio_spi_master_if bus1 ();

   radio_spi_master #(.CLK_DIV(4), .RADIO_BITS(18), .DAC_BITS(16)) dut (
      .converter_clock_in(clk),
      .reset_n           (reset_n),
      .bus               (bus)
   );

   radio_spi_master #(.CLK_DIV(1), .RADIO_BITS(18), .DAC_BITS(16)) dut1 (
      .converter_clock_in(clk),
      .reset_n           (reset_n),
      .bus               (bus1)
   );

   typedef struct {
      bit          tgt;
      logic [17:0] word;
      int          nbits;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Pin monitor for the CLK_DIV=4 instance; snapshots per-word counters on each done pulse.
   int          edges, rcs_low, dcs_low, gap_run, last_gap, done_count;
   logic [17:0] cap;
   bit          both_low, idle_data, prev_sclk;
   int          s_edges, s_rcs, s_dcs;
   logic [17:0] s_cap;
   bit          s_both, s_idle;

   initial begin
      edges = 0; rcs_low = 0; dcs_low = 0; gap_run = 0; last_gap = 0; done_count = 0;
      cap = '0; both_low = 0; idle_data = 0; prev_sclk = 0;
      s_edges = 0; s_rcs = 0; s_dcs = 0; s_cap = '0; s_both = 0; s_idle = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            edges = 0; rcs_low = 0; dcs_low = 0; cap = '0;
            both_low = 0; idle_data = 0; prev_sclk = 0; gap_run = 0;
         end else begin
            if (bus.controller_spi_clk && !prev_sclk) begin
               cap = {cap[16:0], bus.controller_spi_data};
               edges++;
            end
            prev_sclk = bus.controller_spi_clk;
            if (!bus.controller_radio_cs) rcs_low++;
            if (!bus.controller_dac_cs) dcs_low++;
            if (!bus.controller_radio_cs && !bus.controller_dac_cs) both_low = 1;
            if (bus.controller_radio_cs && bus.controller_dac_cs) begin
               if (bus.controller_spi_data) idle_data = 1;
               gap_run++;
            end else if (gap_run > 0) begin
               last_gap = gap_run;
               gap_run  = 0;
            end
            if (bus.done) begin
               s_edges = edges; s_rcs = rcs_low; s_dcs = dcs_low; s_cap = cap;
               s_both = both_low; s_idle = idle_data;
               edges = 0; rcs_low = 0; dcs_low = 0; cap = '0; both_low = 0; idle_data = 0;
               done_count++;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a negedge with the DUT idle; returns just after the acceptance edge.
   task automatic issue(input bit tgt, input logic [0:17] d);
      exp_t        e;
      logic [15:0] dw;
      dw      = d[2:17];
      e.tgt   = tgt;
      e.nbits = tgt ? 16 : 18;
      e.word  = tgt ? {2'b00, dw} : d;
      sb.push_back(e);
      bus.cmd_valid  = 1'b1;
      bus.cmd_target = tgt;
      bus.cmd_data   = d;
      @(posedge clk);
      #1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_target = ~tgt;
      bus.cmd_data   = ~d;
   endtask

   // lat is the index of the done cycle (1 = first cycle after acceptance), 0 on timeout.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      #1;
   endtask

   task automatic pop_exp(output exp_t e);
      e.tgt = 0; e.word = '0; e.nbits = -1;
      if (sb.size() > 0) e = sb.pop_front();
   endtask

   task automatic test_reset();
      bus.cmd_valid = 1'b0; bus.cmd_target = 1'b0; bus.cmd_data = '0;
      bus1.cmd_valid = 1'b0; bus1.cmd_target = 1'b0; bus1.cmd_data = '0;
      reset_n = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.controller_spi_clk, bus.controller_spi_data, bus.controller_radio_cs,
           bus.controller_dac_cs, bus.busy, bus.done, bus.cmd_ready} !== 7'b0011000) begin
         n_fail++;
         $display("FAIL reset_outputs: got sclk,data,rcs,dcs,busy,done,ready=%b expected 0011000",
                  {bus.controller_spi_clk, bus.controller_spi_data, bus.controller_radio_cs,
                   bus.controller_dac_cs, bus.busy, bus.done, bus.cmd_ready});
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_ready: got ready=%b busy=%b expected ready=1 busy=0",
                  bus.cmd_ready, bus.busy);
      end
   endtask

   task automatic test_radio_write();
      exp_t e;
      int   lat;
      issue(1'b0, 18'h2A5C3);
      wait_done(lat);
      pop_exp(e);
      n_checks++;
      if (lat !== 156) begin n_fail++; $display("FAIL radio_latency: got %0d expected 156", lat); end
      n_checks++;
      if (s_edges !== e.nbits) begin
         n_fail++; $display("FAIL radio_edges: got %0d expected %0d", s_edges, e.nbits);
      end
      n_checks++;
      if (s_cap !== e.word) begin
         n_fail++; $display("FAIL radio_data: got %h expected %h", s_cap, e.word);
      end
      n_checks++;
      if (s_rcs !== 148 || s_dcs !== 0) begin
         n_fail++; $display("FAIL radio_cs: got rcs_low=%0d dcs_low=%0d expected 148/0", s_rcs, s_dcs);
      end
      n_checks++;
      if (s_both !== 1'b0 || s_idle !== 1'b0) begin
         n_fail++; $display("FAIL radio_invariants: got both_low=%b idle_data=%b expected 0/0",
                            s_both, s_idle);
      end
   endtask

   task automatic test_dac_write();
      exp_t e;
      int   lat;
      issue(1'b1, 18'h3A55A);
      wait_done(lat);
      pop_exp(e);
      n_checks++;
      if (lat !== 140) begin n_fail++; $display("FAIL dac_latency: got %0d expected 140", lat); end
      n_checks++;
      if (s_edges !== 16) begin n_fail++; $display("FAIL dac_edges: got %0d expected 16", s_edges); end
      n_checks++;
      if (s_cap !== e.word) begin
         n_fail++; $display("FAIL dac_data: got %h expected %h", s_cap, e.word);
      end
      n_checks++;
      if (s_dcs !== 132 || s_rcs !== 0) begin
         n_fail++; $display("FAIL dac_cs: got dcs_low=%0d rcs_low=%0d expected 132/0", s_dcs, s_rcs);
      end
      n_checks++;
      if (s_both !== 1'b0 || s_idle !== 1'b0) begin
         n_fail++; $display("FAIL dac_invariants: got both_low=%b idle_data=%b expected 0/0",
                            s_both, s_idle);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   lat;
      issue(1'b0, 18'h0F0F1);
      wait_done(lat);
      pop_exp(e);
      n_checks++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_ready_in_done: got %b expected 1", bus.cmd_ready);
      end
      n_checks++;
      if (lat !== 156 || s_cap !== e.word) begin
         n_fail++; $display("FAIL b2b_first_word: got lat=%0d data=%h expected 156/%h",
                            lat, s_cap, e.word);
      end
      issue(1'b1, 18'h1C3E7);
      wait_done(lat);
      pop_exp(e);
      n_checks++;
      if (lat !== 140 || s_cap !== e.word) begin
         n_fail++; $display("FAIL b2b_second_word: got lat=%0d data=%h expected 140/%h",
                            lat, s_cap, e.word);
      end
      n_checks++;
      if (last_gap !== 8) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d expected 8", last_gap); end
   endtask

   task automatic test_ignore_busy();
      exp_t e;
      int   lat, d0;
      d0 = done_count;
      issue(1'b0, 18'h15A3C);
      repeat (40) @(negedge clk);
      n_checks++;
      if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_flags: got ready=%b busy=%b expected 0/1",
                            bus.cmd_ready, bus.busy);
      end
      bus.cmd_valid = 1'b1; bus.cmd_target = 1'b1; bus.cmd_data = 18'h3FFFF;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      wait_done(lat);
      pop_exp(e);
      n_checks++;
      if (lat !== 116 || s_cap !== e.word || s_edges !== 18) begin
         n_fail++; $display("FAIL ignore_word: got lat=%0d data=%h edges=%0d expected 116/%h/18",
                            lat, s_cap, s_edges, e.word);
      end
      repeat (200) @(negedge clk);
      n_checks++;
      if (done_count - d0 !== 1) begin
         n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", done_count - d0);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   lat, d0;
      bit   hit;
      d0  = done_count;
      hit = 0;
      issue(1'b0, 18'h2A5C3);
      for (int i = 0; i < 300 && !hit; i++) begin
         @(negedge clk);
         #1;
         if (edges >= 7) hit = 1;
      end
      n_checks++;
      if (!hit) begin n_fail++; $display("FAIL midreset_reach_bit7: got 0 expected 1"); end
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.controller_spi_clk, bus.controller_spi_data, bus.controller_radio_cs,
           bus.controller_dac_cs, bus.busy, bus.done, bus.cmd_ready} !== 7'b0011000) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %b expected 0011000",
                  {bus.controller_spi_clk, bus.controller_spi_data, bus.controller_radio_cs,
                   bus.controller_dac_cs, bus.busy, bus.done, bus.cmd_ready});
      end
      pop_exp(e);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (200) @(negedge clk);
      n_checks++;
      if (done_count !== d0) begin
         n_fail++; $display("FAIL midreset_no_done: got %0d expected %0d", done_count, d0);
      end
      issue(1'b1, 18'h0BEEF);
      wait_done(lat);
      pop_exp(e);
      n_checks++;
      if (lat !== 140 || s_cap !== e.word) begin
         n_fail++; $display("FAIL midreset_fresh_word: got lat=%0d data=%h expected 140/%h",
                            lat, s_cap, e.word);
      end
   endtask

   task automatic test_clk_div1();
      logic [17:0] cap1;
      int          e1, lat;
      bit          prev, toggles_ok;
      @(negedge clk);
      bus1.cmd_valid = 1'b1; bus1.cmd_target = 1'b0; bus1.cmd_data = 18'h1C2B7;
      @(posedge clk);
      #1;
      bus1.cmd_valid = 1'b0; bus1.cmd_data = '0;
      cap1 = '0; e1 = 0; lat = 0; prev = 0; toggles_ok = 1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (bus1.controller_spi_clk && !prev) begin
            cap1 = {cap1[16:0], bus1.controller_spi_data};
            e1++;
         end
         if (i >= 2 && i <= 37 && bus1.controller_spi_clk == prev) toggles_ok = 0;
         prev = bus1.controller_spi_clk;
         if (bus1.done) begin
            lat = i;
            break;
         end
      end
      n_checks++;
      if (lat !== 39) begin n_fail++; $display("FAIL div1_latency: got %0d expected 39", lat); end
      n_checks++;
      if (e1 !== 18 || cap1 !== 18'h1C2B7) begin
         n_fail++; $display("FAIL div1_data: got edges=%0d data=%h expected 18/1c2b7", e1, cap1);
      end
      n_checks++;
      if (!toggles_ok) begin n_fail++; $display("FAIL div1_sclk_rate: got 0 expected 1"); end
   endtask

   initial begin
      test_reset();
      test_radio_write();
      test_dac_write();
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid();
      test_clk_div1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
